// File: rtl/maze_solver_param.sv
// maze_solver_param: N x N binary-maze shortest-path solver (serial load, parallel flood fill, path trace-back).
// Optional feature macro: MAZE_PATH_LEN_EN adds the path_len output.
module maze_solver_param #(
  parameter int N       = 15,
  parameter int CW      = 4,
  parameter int LW      = 8,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = N - 2,
  parameter int GOAL_Y  = N - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          maze,
  output logic          out_valid,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          maze_not_valid,
`ifdef MAZE_PATH_LEN_EN
  output logic [LW-1:0] path_len,
`endif
  output logic          busy
);

  localparam int CELLS = N * N;
  localparam int KW    = $clog2(CELLS);
  localparam int S_IDX = START_Y * N + START_X;
  localparam int G_IDX = GOAL_Y * N + GOAL_X;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLOOD = 3'd2,
    S_TRACE = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CELLS-1:0]     map_q, map_d;
  logic [CELLS-1:0]     vis_q, vis_d;
  logic [2*CELLS-1:0]   par_q, par_d;
  logic [KW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        len_q, len_d;
  logic [CW-1:0]        cur_x_q, cur_x_d;
  logic [CW-1:0]        cur_y_q, cur_y_d;
  logic                 out_valid_q, out_valid_d;
  logic [CW-1:0]        out_x_q, out_x_d;
  logic [CW-1:0]        out_y_q, out_y_d;
  logic                 mnv_q, mnv_d;
  logic                 busy_q, busy_d;

  logic [CELLS-1:0]     flood_vis;
  logic [2*CELLS-1:0]   flood_par;
  logic                 flood_changed;
  int                   cur_idx;
  logic [1:0]           cur_dir;

  // Neighbours outside the grid read as walls, i.e. never visited.
  function automatic logic cell_at(input logic [CELLS-1:0] v, input int x, input int y);
    if (x < 0 || y < 0 || x >= N || y >= N) begin
      return 1'b0;
    end else begin
      return v[y*N + x];
    end
  endfunction

  // One wavefront step for every cell at once; parent priority is up, left, down, right.
  always_comb begin
    int idx;
    flood_vis = vis_q;
    flood_par = par_q;
    for (int y = 0; y < N; y++) begin
      for (int x = 0; x < N; x++) begin
        idx = y * N + x;
        if (!map_q[idx] && !vis_q[idx]) begin
          if (cell_at(vis_q, x, y - 1)) begin
            flood_vis[idx] = 1'b1;
            flood_par[2*idx +: 2] = DIR_UP;
          end else if (cell_at(vis_q, x - 1, y)) begin
            flood_vis[idx] = 1'b1;
            flood_par[2*idx +: 2] = DIR_LEFT;
          end else if (cell_at(vis_q, x, y + 1)) begin
            flood_vis[idx] = 1'b1;
            flood_par[2*idx +: 2] = DIR_DOWN;
          end else if (cell_at(vis_q, x + 1, y)) begin
            flood_vis[idx] = 1'b1;
            flood_par[2*idx +: 2] = DIR_RIGHT;
          end else begin
            flood_vis[idx] = 1'b0;
          end
        end else begin
          flood_vis[idx] = vis_q[idx];
        end
      end
    end
    flood_changed = (flood_vis != vis_q);
    cur_idx = int'(cur_y_q) * N + int'(cur_x_q);
    cur_dir = par_q[2*cur_idx +: 2];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    map_d       = map_q;
    vis_d       = vis_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    out_valid_d = 1'b0;
    out_x_d     = {CW{1'b0}};
    out_y_d     = {CW{1'b0}};
    mnv_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !busy_q) begin
          map_d    = {CELLS{1'b0}};
          map_d[0] = maze;
          vis_d    = {CELLS{1'b0}};
          par_d    = {(2*CELLS){1'b0}};
          cnt_d    = KW'(1);
          len_d    = {LW{1'b0}};
          state_d  = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          map_d[cnt_q] = maze;
          cnt_d        = cnt_q + KW'(1);
          if (cnt_q == KW'(CELLS - 1)) begin
            vis_d[S_IDX] = ~map_d[S_IDX];
            state_d      = S_FLOOD;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLOOD: begin
        vis_d = flood_vis;
        par_d = flood_par;
        len_d = len_q + LW'(1);
        // Saturated length can only mean corrupted state, so bail out rather than spin.
        if (flood_vis[G_IDX]) begin
          state_d = S_TRACE;
          cur_x_d = CW'(GOAL_X);
          cur_y_d = CW'(GOAL_Y);
        end else if (!flood_changed || map_q[G_IDX] || len_q == {LW{1'b1}}) begin
          state_d = S_FAIL;
          mnv_d   = 1'b1;
        end else begin
          state_d = S_FLOOD;
        end
      end
      S_TRACE: begin
        out_valid_d = 1'b1;
        out_x_d     = cur_x_q;
        out_y_d     = cur_y_q;
        case (cur_dir)
          DIR_UP:    cur_y_d = cur_y_q - CW'(1);
          DIR_LEFT:  cur_x_d = cur_x_q - CW'(1);
          DIR_DOWN:  cur_y_d = cur_y_q + CW'(1);
          DIR_RIGHT: cur_x_d = cur_x_q + CW'(1);
          default:   cur_x_d = cur_x_q;
        endcase
        if (cur_x_q == CW'(START_X) && cur_y_q == CW'(START_Y)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TRACE;
        end
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // busy also spans the final path beat, which is emitted after the state has left TRACE.
    busy_d = (state_d == S_FLOOD) || (state_d == S_TRACE) || (state_d == S_FAIL) ||
             (state_q == S_TRACE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      map_q       <= {CELLS{1'b0}};
      vis_q       <= {CELLS{1'b0}};
      par_q       <= {(2*CELLS){1'b0}};
      cnt_q       <= {KW{1'b0}};
      len_q       <= {LW{1'b0}};
      cur_x_q     <= {CW{1'b0}};
      cur_y_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_x_q     <= {CW{1'b0}};
      out_y_q     <= {CW{1'b0}};
      mnv_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      vis_q       <= vis_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      mnv_q       <= mnv_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_x          = out_x_q;
  assign out_y          = out_y_q;
  assign maze_not_valid = mnv_q;
  assign busy           = busy_q;

`ifdef MAZE_PATH_LEN_EN
  logic [LW-1:0] path_len_q, path_len_d;

  // path_len shows L from TRACE entry through the last emitted coordinate.
  always_comb begin
    if (state_d == S_TRACE || state_q == S_TRACE) begin
      path_len_d = len_d;
    end else begin
      path_len_d = {LW{1'b0}};
    end
  end

  // Path-length output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      path_len_q <= {LW{1'b0}};
    end else begin
      path_len_q <= path_len_d;
    end
  end

  assign path_len = path_len_q;
`endif

endmodule

// File: doc/maze_solver_param.md
Name: maze_solver_param

Overview:
- Parametrised N×N binary-maze shortest-path solver.
- Loads a maze serially, one bit per in_valid cycle, then runs a parallel wavefront flood fill from START to GOAL.
- On success, streams the shortest path back from GOAL to START as one coordinate per cycle. On failure, flags an unsolvable maze.
- Next-generation solver for the maze datapath: generalises the fixed 15×15 BFS engine to any odd N.

Parameters:
- N, 15, maze side length; odd, 5..15.
- CW, 4, coordinate width; must satisfy 2^CW ≥ N.
- LW, 8, path-length counter width; must satisfy 2^LW > N*N.
- START_X, 1, start column.
- START_Y, 1, start row.
- GOAL_X, N-2, goal column.
- GOAL_Y, N-2, goal row.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset: asynchronous, active-low.
- in_valid  input  1  maze bit on `maze` is valid this cycle.
- maze  input  1  cell value: 0 = open, 1 = wall.
- out_valid  output  1  out_x/out_y carry one path coordinate.
- out_x  output  CW  path column.
- out_y  output  CW  path row.
- maze_not_valid  output  1  one-cycle pulse: no path exists.
- busy  output  1  high in FLOOD, TRACE and FAIL; in_valid is ignored while high.

Behaviour:

Reset:
- Asynchronous reset: all outputs 0, state IDLE.
- Map, visited, parent and counters cleared.
- Reset mid-operation aborts immediately. No partial output follows deassertion.

Coordinates and loading:
- x = column, y = row; "up" = y-1.
- Load order is raster, row-major: bit k maps to (x = k mod N, y = k div N).
- Only cycles with in_valid=1 count; gaps are allowed.

States:
- IDLE: waits for the first in_valid, which stores bit 0 and moves to LOAD.
- LOAD: stores bits until N*N bits are received, then moves to FLOOD next cycle.
  - Visited is seeded with START only, and only if START is open.
- FLOOD, per cycle, in parallel for all cells:
  - An open, unvisited cell with a visited 4-neighbour becomes visited.
  - Parent pointer (2 bits) records the first visited neighbour in priority order up, left, down, right.
  - Out-of-range neighbours count as walls.
  - Path-length counter L increments each FLOOD cycle.
  - If GOAL is visited after the update, go to TRACE.
  - Else if no cell changed this cycle, go to FAIL.
  - Goal test has priority over the no-change test.
- TRACE:
  - Cursor starts at GOAL. Each cycle: out_valid=1, out_x/out_y = cursor, then cursor moves to its parent.
  - The cycle that outputs START is the last; next state is IDLE.
  - Exactly L+1 coordinates are emitted on consecutive cycles, with no gaps.
- FAIL: maze_not_valid=1 for exactly one cycle, then IDLE.

Output rules:
- out_x/out_y are 0 whenever out_valid=0.
- out_valid and maze_not_valid are never high together.
- START walled or GOAL walled: FAIL after the first FLOOD cycle.
- START==GOAL is not a legal parameterisation.

Latency:
- First out_valid occurs L+1 cycles after the cycle the last maze bit is sampled, where L = shortest step count.
- Back-to-back mazes: a new load may begin in the cycle after the IDLE return.

Optional Feature:
- Macro: MAZE_PATH_LEN_EN.
- When defined: adds output port path_len (LW bits).
  - Holds L throughout TRACE.
  - Holds 0 in all other states, including during the maze_not_valid pulse.
- When undefined: port and its logic are absent. All other behaviour is identical.

Test Plan:
1. N=15, border walls, interior all open -> after 24 FLOOD cycles, 25 outputs in this order: (13,13),(13,12)…(13,1),(12,1)…(1,1); then maze_not_valid never asserted and busy drops.
2. N=15, interior open except full wall column x=7 -> maze_not_valid pulses exactly 1 cycle; out_valid stays 0; busy drops next cycle.
3. N=5, only (1,1),(2,1),(3,1),(3,2),(3,3) open -> outputs (3,3),(3,2),(3,1),(2,1),(1,1); with MAZE_PATH_LEN_EN, path_len=4 on every output cycle.
4. N=5, START (1,1) walled -> FAIL after exactly 1 FLOOD cycle; no out_valid.
5. Case 1 loaded with random in_valid gaps (30% idle cycles) -> identical output sequence.
6. rst_n pulsed low mid-FLOOD of case 1 -> outputs 0 immediately; reloading case 3 yields exactly case 3's sequence.
